bus_interface: RTL and testbench

BUS_INTERFACE -- requirements
Module: bus_interface

---
 rtl/bus_interface.sv | 74 +++++++
 tb/tb_bus_interface.sv | 91 +++++++++
 2 files changed

// File: rtl/bus_interface.sv
// bus_interface: APB-style FSM driving a registered one-hot sub-block enable.
// Define BUS_INTERFACE_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module bus_interface #(
  parameter int ADDR_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     i_Pclk,
  input  logic                     i_Rst,
  input  logic                     i_Psel,
  input  logic                     i_Penable,
  input  logic [ADDR_WIDTH-1:0]    i_Paddr,
  input  logic                     i_Pwrite,
  input  logic                     i_Pready,
  output logic [2**ADDR_WIDTH-1:0] o_Enable
);
  localparam int N = 2**ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic write_q, write_d;
  logic [N-1:0] enable_q, enable_d;
  logic timeout;
  logic unused_ok;
  // Direction is captured for the sub-blocks' benefit only; it never steers the enable.
  assign unused_ok = write_q ^ (TIMEOUT_CYCLES > 0);
  assign o_Enable = enable_q;
`ifdef BUS_INTERFACE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
  assign timeout = (state_q == ACCESS) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge i_Pclk or posedge i_Rst)
    if (i_Rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    enable_d = '0;
    case (state_q)
      IDLE, DONE: if (i_Psel && !i_Penable) begin
        state_d = SETUP;
        addr_d  = i_Paddr;
        write_d = i_Pwrite;
      end else if (!i_Psel) state_d = IDLE;
      SETUP: if (!i_Psel) state_d = IDLE;
      else if (i_Penable) begin
        state_d  = ACCESS;
        enable_d = N'(1) << addr_q;
      end else begin
        addr_d  = i_Paddr;
        write_d = i_Pwrite;
      end
      ACCESS: if (!i_Psel) state_d = IDLE;
      else if (i_Pready || timeout) state_d = DONE;
      else enable_d = enable_q;
    endcase
  end
  always_ff @(posedge i_Pclk or posedge i_Rst)
    if (i_Rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      enable_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      enable_q <= enable_d;
    end
endmodule

// File: tb/tb_bus_interface.sv
// tb_bus_interface: directed and random APB transfers checked against a transfer-level model.
module tb_bus_interface;
  localparam int AW = 1;
  localparam int N  = 2**AW;
  localparam int TO = 4;
  logic clk = 0, rst = 1, sel = 0, en = 0, wr = 0, rdy = 0;
  logic [AW-1:0] addr = '0;
  logic [N-1:0] enable;
  int n_checks = 0, n_fail = 0;
  int setup_a = -1, active_a = -1, waits = 0;
  always #5 clk = ~clk;
  bus_interface #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .i_Pclk(clk), .i_Rst(rst), .i_Psel(sel), .i_Penable(en), .i_Paddr(addr),
    .i_Pwrite(wr), .i_Pready(rdy), .o_Enable(enable)
  );
  function automatic logic [N-1:0] exp_en();
    return (active_a < 0) ? '0 : N'(1 << active_a);
  endfunction
  task automatic check(input string tag, input logic [N-1:0] exp);
    n_checks++;
    assert (enable === exp) else begin
      n_fail++;
      $error("FAIL %s: o_Enable=%b expected %b", tag, enable, exp);
    end
    n_checks++;
    assert ($countones(enable) <= 1) else begin
      n_fail++;
      $error("FAIL %s_onehot: o_Enable=%b expected at most one bit", tag, enable);
    end
  endtask
  task automatic model_edge();
    bit to = 0;
`ifdef BUS_INTERFACE_TIMEOUT_EN
    to = (waits == TO - 1);
`endif
    if (active_a >= 0) begin
      if (!sel || rdy || to) active_a = -1;
      else waits++;
    end else if (setup_a >= 0) begin
      if (!sel) setup_a = -1;
      else if (en) begin
        active_a = setup_a;
        setup_a  = -1;
        waits    = 0;
      end else setup_a = int'(addr);
    end else if (sel && !en) setup_a = int'(addr);
  endtask
  task automatic step(input string tag, input bit s, input bit e, input logic [AW-1:0] a,
                      input bit w, input bit r);
    sel = s; en = e; addr = a; wr = w; rdy = r;
    @(posedge clk);
    model_edge();
    #1;
    check(tag, exp_en());
  endtask
  initial begin
    #2 check("reset", '0);
    #10 rst = 0;
    step("no_setup", 1, 1, 1, 0, 0);
    step("no_setup2", 1, 1, 1, 0, 0);
    step("idle", 0, 0, 0, 0, 0);
    step("rd_setup", 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step("rd_wait", 1, 1, 1'(i), 1'(i), 0);
    step("rd_ready", 1, 1, 1, 0, 1);
    step("rd_hold", 1, 1, 1, 0, 0);
    step("idle2", 0, 0, 0, 0, 0);
    step("a0_setup", 1, 0, 0, 1, 1);
    step("a0_access", 1, 1, 0, 1, 1);
    step("a0_done", 1, 1, 0, 1, 1);
    step("b2b_setup", 1, 0, 1, 0, 0);
    step("b2b_access", 1, 1, 1, 0, 0);
    step("abort", 0, 1, 1, 0, 0);
    step("abort_idle", 1, 1, 1, 0, 0);
    step("re_setup", 1, 0, 0, 0, 0);
    step("re_setup2", 1, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) step("to_wait", 1, 1, 0, 0, 0);
    step("to_end", 0, 0, 0, 0, 0);
    step("rst_setup", 1, 0, 1, 0, 0);
    step("rst_access", 1, 1, 1, 0, 0);
    rst = 1;
    setup_a = -1; active_a = -1; waits = 0;
    #1 check("rst_async", '0);
    #3 rst = 0;
    step("post_rst_setup", 1, 0, 1, 0, 0);
    step("post_rst_access", 1, 1, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      step("random", ($urandom % 4) != 0, $urandom % 2, AW'($urandom), $urandom % 2, ($urandom % 3) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
